// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter/sequencer for the single-port program/data memory.
//   Fetch (read-only) and execute (read/write) requests are serialised into
//   fixed three-cycle transactions: IDLE (sample/grant) -> ACCESS (drive the
//   memory strobe) -> RESP (one-cycle acknowledge). All outputs are registered.
//
//   Build option: define MEM_ARB_FIXED_PRI_EN to replace round-robin tie
//   breaking with fixed fetch priority (execute may then starve).
//
// Ports
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   F_REQ/F_ADDR    fetch request (level) and address
//   F_ACK/F_RDATA   fetch completion pulse and read data (held after ACK)
//   E_REQ/E_WE      execute request (level), 1 = write
//   E_ADDR/E_WDATA  execute address and write data
//   E_ACK/E_RDATA   execute completion pulse and read data (held after ACK)
//   MEM_AR          memory address
//   MEM_READ/WRITE  memory strobes, only ever high in ACCESS
//   MEM_INDATA      memory write data
//   MEM_OUTDATA     memory read data, combinational from MEM_AR
//   BUSY            high during ACCESS and RESP
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              F_REQ,
    input  logic [ADDR_W-1:0] F_ADDR,
    output logic              F_ACK,
    output logic [DATA_W-1:0] F_RDATA,
    input  logic              E_REQ,
    input  logic              E_WE,
    input  logic [ADDR_W-1:0] E_ADDR,
    input  logic [DATA_W-1:0] E_WDATA,
    output logic              E_ACK,
    output logic [DATA_W-1:0] E_RDATA,
    output logic [ADDR_W-1:0] MEM_AR,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [DATA_W-1:0] MEM_INDATA,
    input  logic [DATA_W-1:0] MEM_OUTDATA,
    output logic              BUSY
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Grant encoding: 0 = fetch, 1 = execute.
    localparam logic GNT_F = 1'b0;
    localparam logic GNT_E = 1'b1;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              we_q, we_n;
    logic              gnt_q, gnt_n;
    logic              last_q, last_n;
    logic              f_ack_q, f_ack_n;
    logic              e_ack_q, e_ack_n;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_n;
    logic [DATA_W-1:0] e_rdata_q, e_rdata_n;
    logic              rd_q, rd_n;
    logic              wr_q, wr_n;
    logic              busy_q, busy_n;
    logic              win_e;

    // Execute wins when it is the only requester, or on a tie when the
    // previous grant went to fetch (round-robin). Fixed priority: fetch
    // always wins a tie.
`ifdef MEM_ARB_FIXED_PRI_EN
    assign win_e = E_REQ && !F_REQ;
`else
    assign win_e = E_REQ && (!F_REQ || (last_q == GNT_F));
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            gnt_q     <= GNT_F;
            last_q    <= GNT_E;
            f_ack_q   <= 1'b0;
            e_ack_q   <= 1'b0;
            f_rdata_q <= '0;
            e_rdata_q <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            we_q      <= we_n;
            gnt_q     <= gnt_n;
            last_q    <= last_n;
            f_ack_q   <= f_ack_n;
            e_ack_q   <= e_ack_n;
            f_rdata_q <= f_rdata_n;
            e_rdata_q <= e_rdata_n;
            rd_q      <= rd_n;
            wr_q      <= wr_n;
            busy_q    <= busy_n;
        end
    end

    // Next-state logic computes the values every output register takes in
    // the following cycle, so strobes/ACK/BUSY line up with the state.
    always_comb begin
        state_n   = state;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        we_n      = we_q;
        gnt_n     = gnt_q;
        last_n    = last_q;
        f_ack_n   = 1'b0;
        e_ack_n   = 1'b0;
        f_rdata_n = f_rdata_q;
        e_rdata_n = e_rdata_q;
        rd_n      = 1'b0;
        wr_n      = 1'b0;
        busy_n    = 1'b0;
        case (state)
            IDLE: begin
                if (F_REQ || E_REQ) begin
                    gnt_n   = win_e;
                    addr_n  = win_e ? E_ADDR : F_ADDR;
                    we_n    = win_e && E_WE;
                    // Fetch carries no data; keep the previous write data.
                    wdata_n = win_e ? E_WDATA : wdata_q;
                    rd_n    = !(win_e && E_WE);
                    wr_n    = win_e && E_WE;
                    busy_n  = 1'b1;
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (gnt_q == GNT_E) e_rdata_n = MEM_OUTDATA;
                    else                f_rdata_n = MEM_OUTDATA;
                end
                f_ack_n = (gnt_q == GNT_F);
                e_ack_n = (gnt_q == GNT_E);
                busy_n  = 1'b1;
                state_n = RESP;
            end
            RESP: begin
                last_n  = gnt_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign F_ACK      = f_ack_q;
    assign E_ACK      = e_ack_q;
    assign F_RDATA    = f_rdata_q;
    assign E_RDATA    = e_rdata_q;
    assign MEM_AR     = addr_q;
    assign MEM_INDATA = wdata_q;
    assign MEM_READ   = rd_q;
    assign MEM_WRITE  = wr_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural 16x8 memory attached.
//   Inputs change and outputs are observed on the falling clock edge.
module tb_mem_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       F_REQ, E_REQ, E_WE;
    logic [3:0] F_ADDR, E_ADDR;
    logic [7:0] E_WDATA;
    logic       F_ACK, E_ACK;
    logic [7:0] F_RDATA, E_RDATA;
    logic [3:0] MEM_AR;
    logic       MEM_READ, MEM_WRITE;
    logic [7:0] MEM_INDATA, MEM_OUTDATA;
    logic       BUSY;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [16];

    always #5 CLK = ~CLK;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] <= 8'(i);
        mem[2]  <= 8'h2C;
        mem[15] <= 8'hF1;
    end

    always @(posedge CLK) if (MEM_WRITE) mem[MEM_AR] <= MEM_INDATA;
    assign MEM_OUTDATA = mem[MEM_AR];

    mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .CLK(CLK), .RST(RST),
        .F_REQ(F_REQ), .F_ADDR(F_ADDR), .F_ACK(F_ACK), .F_RDATA(F_RDATA),
        .E_REQ(E_REQ), .E_WE(E_WE), .E_ADDR(E_ADDR), .E_WDATA(E_WDATA),
        .E_ACK(E_ACK), .E_RDATA(E_RDATA),
        .MEM_AR(MEM_AR), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_INDATA(MEM_INDATA), .MEM_OUTDATA(MEM_OUTDATA), .BUSY(BUSY)
    );

    task automatic test_reset();
        RST = 1'b1; F_REQ = 1'b1; E_REQ = 1'b1;
        repeat (2) @(negedge CLK);
        total++; if (F_ACK !== 1'b0)      begin bad++; $display("FAIL rst_f_ack got=%0h want=0", F_ACK); end
        total++; if (E_ACK !== 1'b0)      begin bad++; $display("FAIL rst_e_ack got=%0h want=0", E_ACK); end
        total++; if (F_RDATA !== 8'h00)   begin bad++; $display("FAIL rst_f_rdata got=%0h want=0", F_RDATA); end
        total++; if (E_RDATA !== 8'h00)   begin bad++; $display("FAIL rst_e_rdata got=%0h want=0", E_RDATA); end
        total++; if (MEM_AR !== 4'h0)     begin bad++; $display("FAIL rst_mem_ar got=%0h want=0", MEM_AR); end
        total++; if (MEM_READ !== 1'b0)   begin bad++; $display("FAIL rst_mem_read got=%0h want=0", MEM_READ); end
        total++; if (MEM_WRITE !== 1'b0)  begin bad++; $display("FAIL rst_mem_write got=%0h want=0", MEM_WRITE); end
        total++; if (MEM_INDATA !== 8'h0) begin bad++; $display("FAIL rst_mem_indata got=%0h want=0", MEM_INDATA); end
        total++; if (BUSY !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%0h want=0", BUSY); end
        RST = 1'b0; F_REQ = 1'b0; E_REQ = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_single_fetch();
        F_REQ = 1'b1; F_ADDR = 4'h2;
        @(negedge CLK);
        total++; if (MEM_READ !== 1'b1)  begin bad++; $display("FAIL fetch_read got=%0h want=1", MEM_READ); end
        total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL fetch_write got=%0h want=0", MEM_WRITE); end
        total++; if (MEM_AR !== 4'h2)    begin bad++; $display("FAIL fetch_ar got=%0h want=2", MEM_AR); end
        total++; if (BUSY !== 1'b1)      begin bad++; $display("FAIL fetch_busy got=%0h want=1", BUSY); end
        @(negedge CLK);
        total++; if (F_ACK !== 1'b1)     begin bad++; $display("FAIL fetch_ack got=%0h want=1", F_ACK); end
        total++; if (F_RDATA !== 8'h2C)  begin bad++; $display("FAIL fetch_rdata got=%0h want=2c", F_RDATA); end
        total++; if (E_ACK !== 1'b0)     begin bad++; $display("FAIL fetch_e_ack got=%0h want=0", E_ACK); end
        total++; if (MEM_READ !== 1'b0)  begin bad++; $display("FAIL fetch_resp_read got=%0h want=0", MEM_READ); end
        F_REQ = 1'b0;
        @(negedge CLK);
        total++; if (F_ACK !== 1'b0)     begin bad++; $display("FAIL fetch_ack_pulse got=%0h want=0", F_ACK); end
        total++; if (F_RDATA !== 8'h2C)  begin bad++; $display("FAIL fetch_rdata_hold got=%0h want=2c", F_RDATA); end
        total++; if (BUSY !== 1'b0)      begin bad++; $display("FAIL fetch_idle_busy got=%0h want=0", BUSY); end
    endtask

    task automatic test_write_read();
        E_REQ = 1'b1; E_WE = 1'b1; E_ADDR = 4'hA; E_WDATA = 8'h5A;
        @(negedge CLK);
        total++; if (MEM_WRITE !== 1'b1)   begin bad++; $display("FAIL wr_write got=%0h want=1", MEM_WRITE); end
        total++; if (MEM_READ !== 1'b0)    begin bad++; $display("FAIL wr_read got=%0h want=0", MEM_READ); end
        total++; if (MEM_INDATA !== 8'h5A) begin bad++; $display("FAIL wr_indata got=%0h want=5a", MEM_INDATA); end
        total++; if (MEM_AR !== 4'hA)      begin bad++; $display("FAIL wr_ar got=%0h want=a", MEM_AR); end
        @(negedge CLK);
        total++; if (E_ACK !== 1'b1)       begin bad++; $display("FAIL wr_ack got=%0h want=1", E_ACK); end
        total++; if (MEM_WRITE !== 1'b0)   begin bad++; $display("FAIL wr_resp_write got=%0h want=0", MEM_WRITE); end
        total++; if (E_RDATA !== 8'h00)    begin bad++; $display("FAIL wr_rdata_kept got=%0h want=0", E_RDATA); end
        E_REQ = 1'b0;
        @(negedge CLK);
        E_REQ = 1'b1; E_WE = 1'b0;
        @(negedge CLK);
        total++; if (MEM_READ !== 1'b1)    begin bad++; $display("FAIL rd_read got=%0h want=1", MEM_READ); end
        @(negedge CLK);
        total++; if (E_ACK !== 1'b1)       begin bad++; $display("FAIL rd_ack got=%0h want=1", E_ACK); end
        total++; if (E_RDATA !== 8'h5A)    begin bad++; $display("FAIL rd_rdata got=%0h want=5a", E_RDATA); end
        E_REQ = 1'b0;
        @(negedge CLK);
    endtask

    // Both requesters hold their requests, dropping only in their ACK cycle.
    task automatic test_simultaneous();
        logic exp_f, exp_e;
        F_ADDR = 4'h2; E_ADDR = 4'hF; E_WE = 1'b0;
        F_REQ = 1'b1; E_REQ = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
`ifdef MEM_ARB_FIXED_PRI_EN
            exp_f = (i % 3 == 2);
            exp_e = 1'b0;
`else
            exp_f = (i == 2) || (i == 8);
            exp_e = (i == 5) || (i == 11);
`endif
            total++; if (F_ACK !== exp_f) begin bad++; $display("FAIL tie_f_ack cyc=%0d got=%0h want=%0h", i, F_ACK, exp_f); end
            total++; if (E_ACK !== exp_e) begin bad++; $display("FAIL tie_e_ack cyc=%0d got=%0h want=%0h", i, E_ACK, exp_e); end
            if (exp_f) begin
                total++; if (F_RDATA !== 8'h2C) begin bad++; $display("FAIL tie_f_rdata cyc=%0d got=%0h want=2c", i, F_RDATA); end
            end
            if (exp_e) begin
                total++; if (E_RDATA !== 8'hF1) begin bad++; $display("FAIL tie_e_rdata cyc=%0d got=%0h want=f1", i, E_RDATA); end
            end
            F_REQ = ~F_ACK;
            E_REQ = ~E_ACK;
        end
        F_REQ = 1'b0; E_REQ = 1'b0;
        @(negedge CLK);
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL tie_end_busy got=%0h want=0", BUSY); end
    endtask

    task automatic test_req_drop();
        E_REQ = 1'b1; E_WE = 1'b0; E_ADDR = 4'h2;
        @(negedge CLK);
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL drop_busy got=%0h want=1", BUSY); end
        E_REQ = 1'b0; E_ADDR = 4'h5;
        @(negedge CLK);
        total++; if (E_ACK !== 1'b1)    begin bad++; $display("FAIL drop_ack got=%0h want=1", E_ACK); end
        total++; if (E_RDATA !== 8'h2C) begin bad++; $display("FAIL drop_rdata got=%0h want=2c", E_RDATA); end
        @(negedge CLK);
        total++; if (E_ACK !== 1'b0)    begin bad++; $display("FAIL drop_ack_end got=%0h want=0", E_ACK); end
        total++; if (BUSY !== 1'b0)     begin bad++; $display("FAIL drop_idle got=%0h want=0", BUSY); end
        total++; if (MEM_READ !== 1'b0) begin bad++; $display("FAIL drop_read got=%0h want=0", MEM_READ); end
    endtask

    task automatic test_reset_access();
        E_REQ = 1'b1; E_WE = 1'b1; E_ADDR = 4'h3; E_WDATA = 8'h77;
        @(negedge CLK);
        total++; if (MEM_WRITE !== 1'b1) begin bad++; $display("FAIL rstacc_write got=%0h want=1", MEM_WRITE); end
        RST = 1'b1; E_REQ = 1'b0;
        @(negedge CLK);
        total++; if (BUSY !== 1'b0)      begin bad++; $display("FAIL rstacc_busy got=%0h want=0", BUSY); end
        total++; if (E_ACK !== 1'b0)     begin bad++; $display("FAIL rstacc_ack got=%0h want=0", E_ACK); end
        total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL rstacc_strobe got=%0h want=0", MEM_WRITE); end
        total++; if (MEM_AR !== 4'h0)    begin bad++; $display("FAIL rstacc_ar got=%0h want=0", MEM_AR); end
        total++; if (mem[3] !== 8'h77)   begin bad++; $display("FAIL rstacc_commit got=%0h want=77", mem[3]); end
        RST = 1'b0;
        @(negedge CLK);
        total++; if (E_ACK !== 1'b0)     begin bad++; $display("FAIL rstacc_ack_late got=%0h want=0", E_ACK); end
        total++; if (BUSY !== 1'b0)      begin bad++; $display("FAIL rstacc_busy_late got=%0h want=0", BUSY); end
    endtask

    initial begin
        RST = 1'b1; F_REQ = 1'b0; E_REQ = 1'b0; E_WE = 1'b0;
        F_ADDR = 4'h0; E_ADDR = 4'h0; E_WDATA = 8'h00;
        @(negedge CLK);
        test_reset();
        test_single_fetch();
        test_write_read();
        test_simultaneous();
        test_req_drop();
        test_reset_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
